// File: rtl/vproc_sld_wb_pack.sv
// Packs consecutive slide-unit result chunks and byte masks into one full-width register write.
// Optional macro VPROC_SLD_WB_SKIP_EMPTY_EN drops writes whose assembled byte enables are all zero.
module vproc_sld_wb_pack #(
  parameter int unsigned SLD_OP_W    = 64,
  parameter int unsigned VREG_W      = 128,
  parameter int unsigned VREG_ADDR_W = 5
) (
  input  logic                   clk_i,
  input  logic                   async_rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [SLD_OP_W-1:0]    in_res_i,
  input  logic [SLD_OP_W/8-1:0]  in_mask_i,
  input  logic [VREG_ADDR_W-1:0] in_vd_i,
  input  logic                   in_last_i,
  output logic                   wr_valid_o,
  input  logic                   wr_ready_i,
  output logic [VREG_ADDR_W-1:0] wr_addr_o,
  output logic [VREG_W-1:0]      wr_data_o,
  output logic [VREG_W/8-1:0]    wr_be_o,
  output logic                   busy_o
);

  localparam int unsigned PARTS  = VREG_W / SLD_OP_W;
  localparam int unsigned PART_W = (PARTS > 1) ? $clog2(PARTS) : 1;
  localparam int unsigned MASK_W = SLD_OP_W / 8;
  localparam int unsigned BE_W   = VREG_W / 8;

  typedef enum logic {
    COLLECT,
    WRITE
  } state_t;

  state_t                 state_reg, state_next;
  logic [PART_W-1:0]      part_reg, part_next;
  logic [VREG_W-1:0]      data_reg, data_next;
  logic [BE_W-1:0]        be_reg, be_next;
  logic [VREG_ADDR_W-1:0] vd_reg, vd_next;
  logic [31:0]            part_idx;
  logic                   accept;
  logic                   last_part;

  assign in_ready_o = (state_reg == COLLECT) | wr_ready_i;
  assign accept     = in_valid_i & in_ready_o;
  assign part_idx   = 32'(part_reg);
  assign last_part  = (part_reg == PART_W'(PARTS - 1));

  always_comb begin
    state_next = state_reg;
    part_next  = part_reg;
    data_next  = data_reg;
    be_next    = be_reg;
    vd_next    = vd_reg;

    // Completing a write clears the buffers before a same-cycle chunk lands in part 0.
    if (state_reg == WRITE && wr_ready_i) begin
      state_next = COLLECT;
      data_next  = '0;
      be_next    = '0;
    end

    if (accept) begin
      data_next[part_idx*SLD_OP_W +: SLD_OP_W] = in_res_i;
      be_next[part_idx*MASK_W +: MASK_W]       = in_mask_i;
      if (part_reg == '0) begin
        vd_next = in_vd_i;
      end
      if (in_last_i || last_part) begin
        state_next = WRITE;
        part_next  = '0;
`ifdef VPROC_SLD_WB_SKIP_EMPTY_EN
        if (be_next == '0) begin
          state_next = COLLECT;
          data_next  = '0;
          be_next    = '0;
        end
`endif
      end else begin
        part_next = part_reg + PART_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_reg <= COLLECT;
      part_reg  <= '0;
      data_reg  <= '0;
      be_reg    <= '0;
      vd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      part_reg  <= part_next;
      data_reg  <= data_next;
      be_reg    <= be_next;
      vd_reg    <= vd_next;
    end
  end

  assign wr_valid_o = (state_reg == WRITE);
  assign wr_addr_o  = vd_reg;
  assign wr_data_o  = data_reg;
  assign wr_be_o    = be_reg;
  assign busy_o     = (state_reg == WRITE) | (part_reg != '0);

endmodule

// File: tb/tb_vproc_sld_wb_pack.sv
// Bench for vproc_sld_wb_pack: directed vector table, hand sequences and random traffic
// checked against a chunk-queue reference model.
module tb_vproc_sld_wb_pack;

  localparam int SLD_OP_W    = 64;
  localparam int VREG_W      = 128;
  localparam int VREG_ADDR_W = 5;
  localparam int PARTS       = VREG_W / SLD_OP_W;
  localparam int MW          = SLD_OP_W / 8;
  localparam int BW          = VREG_W / 8;
`ifdef VPROC_SLD_WB_SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic                   clk_i = 1'b0;
  logic                   async_rst_ni = 1'b0;
  logic                   in_valid_i = 1'b0;
  logic                   in_ready_o;
  logic [SLD_OP_W-1:0]    in_res_i = '0;
  logic [MW-1:0]          in_mask_i = '0;
  logic [VREG_ADDR_W-1:0] in_vd_i = '0;
  logic                   in_last_i = 1'b0;
  logic                   wr_valid_o;
  logic                   wr_ready_i = 1'b0;
  logic [VREG_ADDR_W-1:0] wr_addr_o;
  logic [VREG_W-1:0]      wr_data_o;
  logic [BW-1:0]          wr_be_o;
  logic                   busy_o;

  vproc_sld_wb_pack #(
    .SLD_OP_W(SLD_OP_W), .VREG_W(VREG_W), .VREG_ADDR_W(VREG_ADDR_W)
  ) dut (
    .clk_i(clk_i), .async_rst_ni(async_rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_res_i(in_res_i),
    .in_mask_i(in_mask_i), .in_vd_i(in_vd_i), .in_last_i(in_last_i),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .wr_be_o(wr_be_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int fails = 0;
  int dut_writes = 0;
  int dut_accepts = 0;

  // Reference model: accepted chunks of the register under assembly, plus the pending write.
  logic [SLD_OP_W-1:0]    q_res[$];
  logic [MW-1:0]          q_mask[$];
  logic [VREG_ADDR_W-1:0] m_vd;
  bit                     pend;
  logic [VREG_ADDR_W-1:0] p_addr;
  logic [VREG_W-1:0]      p_data;
  logic [BW-1:0]          p_be;

  task automatic chk(input string name, input logic [VREG_W-1:0] act, input logic [VREG_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q_res.delete();
    q_mask.delete();
    m_vd = '0;
    pend = 1'b0;
    p_addr = '0;
    p_data = '0;
    p_be = '0;
  endtask

  task automatic model_check();
    chk("in_ready", VREG_W'(in_ready_o), VREG_W'(!pend || wr_ready_i));
    chk("wr_valid", VREG_W'(wr_valid_o), VREG_W'(pend));
    chk("busy", VREG_W'(busy_o), VREG_W'(pend || q_res.size() != 0));
    if (pend) begin
      chk("wr_addr", VREG_W'(wr_addr_o), VREG_W'(p_addr));
      chk("wr_data", wr_data_o, p_data);
      chk("wr_be", VREG_W'(wr_be_o), VREG_W'(p_be));
    end
  endtask

  task automatic model_update();
    bit rdy;
    logic [VREG_W-1:0] d;
    logic [BW-1:0] b;
    rdy = !pend || wr_ready_i;
    if (pend && wr_ready_i) pend = 1'b0;
    if (in_valid_i && rdy) begin
      if (q_res.size() == 0) m_vd = in_vd_i;
      q_res.push_back(in_res_i);
      q_mask.push_back(in_mask_i);
      if (in_last_i || q_res.size() == PARTS) begin
        d = '0;
        b = '0;
        foreach (q_res[k]) begin
          d[k*SLD_OP_W +: SLD_OP_W] = q_res[k];
          b[k*MW +: MW] = q_mask[k];
        end
        if (!(SKIP && b == '0)) begin
          pend = 1'b1;
          p_addr = m_vd;
          p_data = d;
          p_be = b;
        end
        q_res.delete();
        q_mask.delete();
      end
    end
  endtask

  task automatic drive(input bit v, input logic [SLD_OP_W-1:0] r, input logic [MW-1:0] m,
                       input logic [VREG_ADDR_W-1:0] d, input bit l, input bit wr);
    in_valid_i = v;
    in_res_i = r;
    in_mask_i = m;
    in_vd_i = d;
    in_last_i = l;
    wr_ready_i = wr;
  endtask

  task automatic finish_cycle();
    model_check();
    if (wr_valid_o && wr_ready_i) dut_writes++;
    if (in_valid_i && in_ready_o) dut_accepts++;
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic cycle(input bit v, input logic [SLD_OP_W-1:0] r, input logic [MW-1:0] m,
                       input logic [VREG_ADDR_W-1:0] d, input bit l, input bit wr);
    drive(v, r, m, d, l, wr);
    @(negedge clk_i);
    finish_cycle();
  endtask

  typedef struct {
    bit                     v;
    logic [SLD_OP_W-1:0]    res;
    logic [MW-1:0]          mask;
    logic [VREG_ADDR_W-1:0] vd;
    bit                     last;
    bit                     rdy;
    bit                     e_ready;
    bit                     e_valid;
    logic [VREG_ADDR_W-1:0] e_addr;
    logic [VREG_W-1:0]      e_data;
    logic [BW-1:0]          e_be;
    bit                     e_busy;
  } vec_t;

  vec_t tbl[5];

  localparam logic [SLD_OP_W-1:0] C11 = 64'h1111_1111_1111_1111;
  localparam logic [SLD_OP_W-1:0] C22 = 64'h2222_2222_2222_2222;
  localparam logic [SLD_OP_W-1:0] C33 = 64'h3333_3333_3333_3333;

  initial begin
    logic [VREG_W-1:0] hold_data;
    int w0;
    int a0;

    tbl[0] = '{1'b1, C11, 8'hFF, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, '0, '0, 1'b0};
    tbl[1] = '{1'b1, C22, 8'h0F, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, '0, '0, 1'b1};
    tbl[2] = '{1'b1, C33, 8'hFF, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, {C22, C11}, 16'h0FFF, 1'b1};
    tbl[3] = '{1'b0, '0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, {64'h0, C33}, 16'h00FF, 1'b1};
    tbl[4] = '{1'b0, '0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, '0, '0, 1'b0};

    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_in_ready", VREG_W'(in_ready_o), VREG_W'(1));
    chk("rst_wr_valid", VREG_W'(wr_valid_o), '0);
    chk("rst_wr_addr", VREG_W'(wr_addr_o), '0);
    chk("rst_wr_data", wr_data_o, '0);
    chk("rst_wr_be", VREG_W'(wr_be_o), '0);
    chk("rst_busy", VREG_W'(busy_o), '0);
    async_rst_ni = 1'b1;

    // Directed vectors: two-chunk register, early-last register, idle.
    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].v, tbl[i].res, tbl[i].mask, tbl[i].vd, tbl[i].last, tbl[i].rdy);
      @(negedge clk_i);
      chk($sformatf("vec%0d_in_ready", i), VREG_W'(in_ready_o), VREG_W'(tbl[i].e_ready));
      chk($sformatf("vec%0d_wr_valid", i), VREG_W'(wr_valid_o), VREG_W'(tbl[i].e_valid));
      chk($sformatf("vec%0d_busy", i), VREG_W'(busy_o), VREG_W'(tbl[i].e_busy));
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d_wr_addr", i), VREG_W'(wr_addr_o), VREG_W'(tbl[i].e_addr));
        chk($sformatf("vec%0d_wr_data", i), wr_data_o, tbl[i].e_data);
        chk($sformatf("vec%0d_wr_be", i), VREG_W'(wr_be_o), VREG_W'(tbl[i].e_be));
      end
      finish_cycle();
    end

    // Write stalled for 5 cycles, then a new chunk accepted as the write completes.
    cycle(1'b1, 64'hA5A5_0000_0000_0001, 8'hFF, 5'd4, 1'b0, 1'b1);
    cycle(1'b1, 64'hA5A5_0000_0000_0002, 8'hF0, 5'd4, 1'b1, 1'b1);
    hold_data = wr_data_o;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 64'hC0DE_0000_0000_0009, 8'hFF, 5'd9, 1'b0, 1'b0);
      chk("stall_wr_data", wr_data_o, hold_data);
      chk("stall_wr_valid", VREG_W'(wr_valid_o), VREG_W'(1));
    end
    cycle(1'b1, 64'hC0DE_0000_0000_0009, 8'hFF, 5'd9, 1'b0, 1'b1);
    cycle(1'b1, 64'hC0DE_0000_0000_000A, 8'hFF, 5'd2, 1'b0, 1'b1);
    chk("after_stall_addr", VREG_W'(wr_addr_o), VREG_W'(9));
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b1);

    // Four back-to-back registers at full rate.
    w0 = dut_writes;
    a0 = dut_accepts;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, {$urandom, $urandom}, 8'hFF, 5'(10 + i / 2), 1'b0, 1'b1);
    end
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b1);
    chk("b2b_accepts", VREG_W'(dut_accepts - a0), VREG_W'(8));
    chk("b2b_writes", VREG_W'(dut_writes - w0), VREG_W'(4));

    // Asynchronous reset after the first chunk of a register.
    w0 = dut_writes;
    cycle(1'b1, 64'hDEAD_BEEF_0000_0006, 8'hFF, 5'd6, 1'b0, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
    async_rst_ni = 1'b0;
    #1;
    chk("arst_in_ready", VREG_W'(in_ready_o), VREG_W'(1));
    chk("arst_wr_valid", VREG_W'(wr_valid_o), '0);
    chk("arst_wr_addr", VREG_W'(wr_addr_o), '0);
    chk("arst_wr_data", wr_data_o, '0);
    chk("arst_wr_be", VREG_W'(wr_be_o), '0);
    chk("arst_busy", VREG_W'(busy_o), '0);
    model_reset();
    #2;
    async_rst_ni = 1'b1;
    repeat (4) cycle(1'b0, '0, '0, '0, 1'b0, 1'b1);
    chk("arst_no_write", VREG_W'(dut_writes - w0), '0);

    // Register whose byte enables are all zero.
    w0 = dut_writes;
    cycle(1'b1, 64'h1234_5678_9ABC_DEF0, 8'h00, 5'd8, 1'b0, 1'b1);
    cycle(1'b1, 64'h0FED_CBA9_8765_4321, 8'h00, 5'd8, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b1);
    chk("zero_mask_writes", VREG_W'(dut_writes - w0), VREG_W'(SKIP ? 0 : 1));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, {$urandom, $urandom},
            (($urandom % 8) == 0) ? 8'h00 : 8'($urandom),
            5'($urandom), ($urandom % 4) == 0, ($urandom % 3) != 0);
    end
    repeat (3) cycle(1'b0, '0, '0, '0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
